// File: rtl/ldpc_wb_responder.sv
// Wishbone classic responder that queues message words for the LDPC encoder,
// captures encoder results, and drives a firmware-written checkbits word onto mprj_io.
module ldpc_wb_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CB_LSB     = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rstn_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] enc_msg_o,
  output logic        enc_valid_o,
  input  logic        enc_ready_i,
  input  logic [31:0] enc_res_i,
  input  logic        enc_res_valid_i,
  output logic [15:0] io_out,
  output logic [15:0] io_oeb
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_STATUS = 6'h01;
  localparam logic [5:0] A_MSG    = 6'h02;
  localparam logic [5:0] A_RESULT = 6'h03;
  localparam logic [5:0] A_CB     = 6'h04;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "FIFO_DEPTH must be a power of 2");
  end
  if ((CB_LSB < 0) || (CB_LSB > 22)) begin : g_bad_cb_lsb
    $fatal(1, "CB_LSB places the checkbits outside mprj_io");
  end

  logic        req, wr, rd;
  logic [5:0]  word;
  logic [31:0] rdata;

  logic        enc_en, flush_q, push_q;
  logic [31:0] push_data;
  logic [15:0] cb_val;
  logic        cb_oe;
  logic        fifo_ovf, res_ovf, res_valid;
  logic [31:0] res_word;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic          empty, full, pop, push_ok, res_rd;

  logic unused_ok;
  assign unused_ok = &{1'b0, wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_sel_i[3]};

  assign req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr   = req & wbs_we_i;
  assign rd   = req & ~wbs_we_i;
  assign word = wbs_adr_i[7:2];

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign pop     = enc_valid_o & enc_ready_i;
  assign push_ok = push_q & ~full;
  assign res_rd  = rd & (word == A_RESULT);

  assign enc_valid_o = enc_en & ~empty;
  assign enc_msg_o   = empty ? 32'h0 : mem[rd_ptr];

  always_comb begin
    rdata = '0;
    case (word)
      A_CTRL:   rdata[0] = enc_en;
      A_STATUS: begin
        rdata[0]   = empty;
        rdata[1]   = full;
        rdata[2]   = res_valid;
        rdata[6:4] = 3'(cnt);
        rdata[8]   = fifo_ovf;
        rdata[9]   = res_ovf;
      end
      A_RESULT: rdata = res_word;
      A_CB:     rdata = {15'h0, cb_oe, cb_val};
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pushes and flushes are staged one cycle so they land after the ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush_q) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      enc_en    <= 1'b0;
      flush_q   <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
      cb_val    <= '0;
      cb_oe     <= 1'b0;
      fifo_ovf  <= 1'b0;
      res_ovf   <= 1'b0;
      res_valid <= 1'b0;
      res_word  <= '0;
      io_out    <= '0;
      io_oeb    <= '1;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rdata : 32'h0;
      flush_q   <= wr & (word == A_CTRL) & wbs_sel_i[0] & wbs_dat_i[1];
      push_q    <= wr & (word == A_MSG);
      push_data <= wbs_dat_i;
      io_out    <= cb_val;
      io_oeb    <= {16{~cb_oe}};

      if (wr && word == A_CTRL && wbs_sel_i[0]) enc_en <= wbs_dat_i[0];
      if (wr && word == A_CB) begin
        if (wbs_sel_i[0]) cb_val[7:0]  <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) cb_val[15:8] <= wbs_dat_i[15:8];
        if (wbs_sel_i[2]) cb_oe        <= wbs_dat_i[16];
      end

      // Sticky set takes priority over a same-cycle W1C.
      if (wr && word == A_STATUS && wbs_sel_i[1]) begin
        if (wbs_dat_i[8]) fifo_ovf <= 1'b0;
        if (wbs_dat_i[9]) res_ovf  <= 1'b0;
      end
      if (push_q && full) fifo_ovf <= 1'b1;

      if (enc_res_valid_i) begin
        res_word  <= enc_res_i;
        res_valid <= 1'b1;
        if (res_valid && !res_rd) res_ovf <= 1'b1;
      end else if (res_rd) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_wb_responder.sv
// Directed bench for ldpc_wb_responder: register map, FIFO handshake, results,
// flush and reset-during-access behaviour.
module tb_ldpc_wb_responder;
  logic        wb_clk_i = 1'b0;
  logic        wb_rstn_i = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] enc_msg_o;
  logic        enc_valid_o;
  logic        enc_ready_i = 1'b0;
  logic [31:0] enc_res_i = '0;
  logic        enc_res_valid_i = 1'b0;
  logic [15:0] io_out, io_oeb;

  int errors = 0;
  int checks = 0;

  ldpc_wb_responder #(.FIFO_DEPTH(4), .CB_LSB(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rstn_i(wb_rstn_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .enc_msg_o(enc_msg_o), .enc_valid_o(enc_valid_o), .enc_ready_i(enc_ready_i),
    .enc_res_i(enc_res_i), .enc_res_valid_i(enc_res_valid_i),
    .io_out(io_out), .io_oeb(io_oeb)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge wb_clk_i); #1;
  endtask

  // Starts at posedge+1 with ack low; returns in the ack cycle with stb dropped.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output logic [31:0] rd);
    int lat = 0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
    do begin step(); lat++; end while (!wbs_ack_o && lat < 20);
    check("ack_latency", lat, 1);
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, adr, 4'hF, 32'h0, r);
    check(tag, r, exp);
    step();
    check("ack_width", {31'h0, wbs_ack_o}, 32'h0);
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic [31:0] r;
    wb_xfer(1'b1, adr, sel, dat, r);
    check("wr_dat_zero", r, 32'h0);
    step();
    check("ack_width", {31'h0, wbs_ack_o}, 32'h0);
  endtask

  initial begin
    logic [31:0] r;
    // Reset state
    repeat (3) step();
    check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_valid", {31'h0, enc_valid_o}, 32'h0);
    check("rst_msg", enc_msg_o, 32'h0);
    check("rst_io_out", {16'h0, io_out}, 32'h0);
    check("rst_io_oeb", {16'h0, io_oeb}, 32'h0000FFFF);
    wb_rstn_i = 1'b1;
    step();
    wb_rd("rd_ctrl0", 32'h00, 32'h0);
    wb_rd("rd_status0", 32'h04, 32'h1);
    wb_rd("rd_msg0", 32'h08, 32'h0);
    wb_rd("rd_result0", 32'h0C, 32'h0);
    wb_rd("rd_cb0", 32'h10, 32'h0);
    wb_rd("rd_unmapped", 32'h14, 32'h0);

    // Checkbits
    wb_wr(32'h10, 4'hF, 32'h0001AB60);
    check("io_out_ab60", {16'h0, io_out}, 32'h0000AB60);
    check("io_oeb_on", {16'h0, io_oeb}, 32'h0);
    wb_wr(32'h10, 4'b0001, 32'h00000061);
    check("io_out_ab61", {16'h0, io_out}, 32'h0000AB61);
    wb_rd("rd_cb1", 32'h10, 32'h0001AB61);

    // FIFO fill past full with encoder disabled
    enc_ready_i = 1'b1;
    for (int i = 1; i <= 5; i++) wb_wr(32'h08, 4'h0, i);
    check("fill_valid_gated", {31'h0, enc_valid_o}, 32'h0);
    wb_rd("status_full", 32'h04, 32'h00000142);
    wb_rd("rd_msg_wo", 32'h08, 32'h0);

    // Enable encoder: one pop per cycle
    wb_xfer(1'b1, 32'h00, 4'hF, 32'h1, r);
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", {31'h0, enc_valid_o}, 32'h1);
      check("drain_msg", enc_msg_o, i);
      step();
    end
    check("drain_empty", {31'h0, enc_valid_o}, 32'h0);
    step();
    wb_rd("status_drained", 32'h04, 32'h00000101);
    wb_wr(32'h04, 4'hF, 32'h00000100);
    wb_rd("status_w1c_fifo", 32'h04, 32'h00000001);

    // Backpressure
    enc_ready_i = 1'b0;
    wb_wr(32'h08, 4'hF, 32'h11);
    wb_wr(32'h08, 4'hF, 32'h12);
    wb_wr(32'h08, 4'hF, 32'h13);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'h0, enc_valid_o}, 32'h1);
      check("bp_msg", enc_msg_o, 32'h11);
      step();
    end
    enc_ready_i = 1'b1;
    step();
    enc_ready_i = 1'b0;
    check("bp_pop1", enc_msg_o, 32'h12);
    step();
    check("bp_hold", enc_msg_o, 32'h12);
    enc_ready_i = 1'b1;
    step();
    check("bp_pop2", enc_msg_o, 32'h13);
    step();
    check("bp_empty", {31'h0, enc_valid_o}, 32'h0);
    enc_ready_i = 1'b0;

    // Results
    enc_res_i = 32'hCAFE0001; enc_res_valid_i = 1'b1;
    step();
    enc_res_i = 32'hCAFE0002;
    step();
    enc_res_valid_i = 1'b0;
    wb_rd("status_res_ovf", 32'h04, 32'h00000205);
    wb_rd("result_last", 32'h0C, 32'hCAFE0002);
    wb_rd("status_res_rd", 32'h04, 32'h00000201);
    wb_wr(32'h04, 4'hF, 32'h00000200);
    wb_rd("status_w1c_res", 32'h04, 32'h00000001);
    wb_rd("result_retained", 32'h0C, 32'hCAFE0002);
    wb_rd("status_res_clr", 32'h04, 32'h00000001);

    // Capture coincident with a RESULT read
    enc_res_i = 32'hCAFE0003; enc_res_valid_i = 1'b1;
    step();
    enc_res_valid_i = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h0C; wbs_sel_i = 4'hF;
    enc_res_i = 32'hCAFE0004; enc_res_valid_i = 1'b1;
    step();
    enc_res_valid_i = 1'b0;
    check("coinc_ack", {31'h0, wbs_ack_o}, 32'h1);
    check("coinc_old", wbs_dat_o, 32'hCAFE0003);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    step();
    wb_rd("coinc_status", 32'h04, 32'h00000005);
    wb_rd("coinc_new", 32'h0C, 32'hCAFE0004);

    // Flush with 3 words queued
    wb_wr(32'h08, 4'hF, 32'h21);
    wb_wr(32'h08, 4'hF, 32'h22);
    wb_wr(32'h08, 4'hF, 32'h23);
    wb_rd("status_three", 32'h04, 32'h00000030);
    wb_xfer(1'b1, 32'h00, 4'hF, 32'h3, r);
    check("flush_ack_cycle", {31'h0, enc_valid_o}, 32'h1);
    step();
    check("flush_valid", {31'h0, enc_valid_o}, 32'h0);
    check("flush_msg", enc_msg_o, 32'h0);
    wb_rd("flush_status", 32'h04, 32'h00000001);
    wb_rd("flush_ctrl", 32'h00, 32'h00000001);

    // Reset asserted during a pending access
    wb_wr(32'h08, 4'hF, 32'h31);
    check("pre_rst_valid", {31'h0, enc_valid_o}, 32'h1);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h00; wbs_sel_i = 4'hF;
    wb_rstn_i = 1'b0;
    step();
    check("rst_stb_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("rst_stb_oeb", {16'h0, io_oeb}, 32'h0000FFFF);
    check("rst_stb_out", {16'h0, io_out}, 32'h0);
    check("rst_stb_valid", {31'h0, enc_valid_o}, 32'h0);
    check("rst_stb_msg", enc_msg_o, 32'h0);
    check("rst_stb_dat", wbs_dat_o, 32'h0);
    step();
    check("rst_stb_ack2", {31'h0, wbs_ack_o}, 32'h0);
    wb_rstn_i = 1'b1;
    step();
    check("post_rst_ack", {31'h0, wbs_ack_o}, 32'h1);
    check("post_rst_dat", wbs_dat_o, 32'h0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    step();
    wb_rd("post_rst_status", 32'h04, 32'h00000001);
    wb_rd("post_rst_cb", 32'h10, 32'h0);
    wb_rd("post_rst_result", 32'h0C, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
